// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: ID, write counter, control, status and twelve scratch words.
// Independent AW/W capture, single outstanding write response, 1-cycle registered read.
module axi_lite_regbank #(
    parameter logic [31:0] ID_VALUE = 32'h5349_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] ctrl_out,
    input  logic [31:0] status_in
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic        aw_held_q, aw_held_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic        w_held_q, w_held_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wcnt_q, wcnt_d;
    logic [31:0] regs_q [16];
    logic [31:0] regs_d [16];

    logic        aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb, wr_idx, rd_idx;
    logic        unused_ok;

    assign s_axi_awready = ~rst & ~aw_held_q & ~bvalid_q;
    assign s_axi_wready  = ~rst & ~w_held_q & ~bvalid_q;
    assign s_axi_arready = ~rst & ~rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign ctrl_out      = regs_q[2];

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // A beat accepted this cycle counts as held, so AW and W together commit at once.
    assign wr_addr = aw_held_q ? aw_addr_q : s_axi_awaddr;
    assign wr_data = w_held_q ? w_data_q : s_axi_wdata;
    assign wr_strb = w_held_q ? w_strb_q : s_axi_wstrb;
    assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    assign wr_idx  = wr_addr[5:2];
    assign wr_ok   = (wr_addr[31:6] == '0) && ((wr_idx == 4'd2) || (wr_idx >= 4'd4));
    assign rd_idx  = s_axi_araddr[5:2];

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], s_axi_araddr[1:0]};

    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wcnt_d    = wcnt_q;
        regs_d    = regs_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = s_axi_awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) begin
                wcnt_d = wcnt_q + 32'd1;
                for (int unsigned b = 0; b < 4; b++) begin
                    if (wr_strb[b]) begin
                        regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        // Reads use current register values, so a same-cycle commit is not visible yet.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (s_axi_araddr[31:6] != '0) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else begin
                rresp_d = RESP_OKAY;
                case (rd_idx)
                    4'd0:    rdata_d = ID_VALUE;
                    4'd1:    rdata_d = wcnt_q;
                    4'd3:    rdata_d = status_in;
                    default: rdata_d = regs_q[rd_idx];
                endcase
            end
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            wcnt_q    <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wcnt_q    <= wcnt_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Randomized self-checking bench for axi_lite_regbank against an array-based register map model.
module tb_axi_lite_regbank;
    localparam logic [31:0] ID = 32'h5349_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [31:0] ctrl_out;
    logic [31:0] status_in = 32'h1357_9BDF;

    always #5 clk = ~clk;

    axi_lite_regbank #(.ID_VALUE(ID)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .ctrl_out(ctrl_out), .status_in(status_in)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [31:0] m_regs [16];
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_cnt = '0;
    endtask

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
        logic [3:0] idx;
        idx = a[5:2];
        if (a[31:6] != 26'd0 || idx == 4'd0 || idx == 4'd1 || idx == 4'd3) begin
            resp = 2'b10;
        end else begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
            m_cnt = m_cnt + 32'd1;
            resp = 2'b00;
        end
    endtask

    task automatic m_read(input logic [31:0] a, input logic [31:0] st,
                          output logic [31:0] d, output logic [1:0] resp);
        logic [3:0] idx;
        idx = a[5:2];
        resp = 2'b00;
        if (a[31:6] != 26'd0) begin
            d = '0;
            resp = 2'b10;
        end else if (idx == 4'd0) d = ID;
        else if (idx == 4'd1) d = m_cnt;
        else if (idx == 4'd3) d = st;
        else d = m_regs[idx];
    endtask

    // Presents AW and W with independent delays; returns at the negedge after the last handshake.
    task automatic write_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_fire, w_fire;
        int cyc = 0;
        while (!(aw_done && w_done)) begin
            check("b_early", 32'(s_axi_bvalid), 32'd0);
            s_axi_awaddr  = a;
            s_axi_wdata   = d;
            s_axi_wstrb   = s;
            s_axi_awvalid = !aw_done && cyc >= aw_dly;
            s_axi_wvalid  = !w_done && cyc >= w_dly;
            aw_fire = s_axi_awvalid && s_axi_awready;
            w_fire  = s_axi_wvalid && s_axi_wready;
            @(posedge clk);
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            @(negedge clk);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            cyc++;
            if (cyc > 40) begin
                check("aw_w_timeout", 32'd1, 32'd0);
                break;
            end
        end
        m_write(a, d, s, resp);
        check("b_latency", 32'(s_axi_bvalid), 32'd1);
    endtask

    task automatic b_accept(input int hold, input logic [1:0] exp_resp);
        for (int i = 0; i < hold; i++) begin
            check("b_hold_valid", 32'(s_axi_bvalid), 32'd1);
            check("b_hold_resp", 32'(s_axi_bresp), 32'(exp_resp));
            check("b_hold_awready", 32'(s_axi_awready), 32'd0);
            check("b_hold_wready", 32'(s_axi_wready), 32'd0);
            @(negedge clk);
        end
        check("bresp", 32'(s_axi_bresp), 32'(exp_resp));
        s_axi_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("b_clear", 32'(s_axi_bvalid), 32'd0);
        check("ctrl_out", ctrl_out, m_regs[2]);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_dly, input int w_dly, input int hold);
        logic [1:0] resp;
        write_req(a, d, s, aw_dly, w_dly, resp);
        b_accept(hold, resp);
    endtask

    task automatic rd(input logic [31:0] a, input int hold);
        logic [31:0] ed;
        logic [1:0] er;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        check("arready", 32'(s_axi_arready), 32'd1);
        m_read(a, status_in, ed, er);
        @(posedge clk);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        status_in = $urandom;
        check("r_latency", 32'(s_axi_rvalid), 32'd1);
        check("rdata", s_axi_rdata, ed);
        check("rresp", 32'(s_axi_rresp), 32'(er));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            status_in = $urandom;
            check("r_hold_valid", 32'(s_axi_rvalid), 32'd1);
            check("r_hold_data", s_axi_rdata, ed);
            check("r_hold_arready", 32'(s_axi_arready), 32'd0);
        end
        s_axi_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_axi_rready = 1'b0;
        check("r_clear", 32'(s_axi_rvalid), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 7) == 0) a = a | (32'h40 << $urandom_range(0, 25));
        return a;
    endfunction

    initial begin
        logic [1:0] resp;
        m_reset();
        #1;
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_wready", 32'(s_axi_wready), 32'd0);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        check("rst_ctrl", ctrl_out, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
        @(negedge clk);

        // Same-cycle AW/W to control, then read back.
        wr(32'h08, 32'hA5A5_1234, 4'hF, 0, 0, 0);
        check("ctrl_a5a5", ctrl_out, 32'hA5A5_1234);
        rd(32'h04, 0);
        check("cnt_one", m_cnt, 32'd1);
        rd(32'h08, 0);

        // W leads AW by three cycles, single byte lane.
        wr(32'h10, 32'hFFFF_FFFF, 4'b0100, 3, 0, 0);
        rd(32'h10, 0);
        check("strobe_model", m_regs[4], 32'h00FF_0000);

        // Error responses and read-only protection.
        write_req(32'h00, 32'hDEAD_BEEF, 4'hF, 0, 0, resp);
        check("ro_slverr", 32'(resp), 32'd2);
        b_accept(0, resp);
        rd(32'h00, 0);
        rd(32'h04, 0);
        rd(32'h40, 0);
        rd(32'h0C, 2);
        wr(32'h0C, 32'h1, 4'hF, 1, 0, 0);
        wr(32'h18, 32'h1234_5678, 4'h0, 0, 2, 0);
        rd(32'h18, 0);

        // Backpressure on both response channels.
        wr(32'h14, 32'hCAFE_F00D, 4'hF, 0, 0, 5);
        rd(32'h14, 5);

        // Counter wrap.
        @(negedge clk);
        force dut.wcnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.wcnt_q;
        m_cnt = 32'hFFFF_FFFF;
        rd(32'h04, 0);
        wr(32'h20, 32'h0BAD_F00D, 4'hF, 0, 1, 0);
        check("cnt_wrap_model", m_cnt, 32'd0);
        rd(32'h04, 0);

        // Randomized mix of writes and reads.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 0)
                wr(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                rd(rand_addr(), $urandom_range(0, 3));
        end

        // Reset while a write response is pending.
        write_req(32'h08, 32'h7777_8888, 4'hF, 0, 0, resp);
        rst = 1'b1;
        #1;
        m_reset();
        check("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("mid_rst_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
        check("mid_rst_ctrl", ctrl_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
        @(negedge clk);
        rd(32'h08, 0);
        rd(32'h04, 0);
        wr(32'h3C, 32'h55AA_55AA, 4'b1001, 2, 1, 1);
        rd(32'h3C, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axi_lite_regbank.md
AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have parameter ID_VALUE, default 32'h5349_0001, holding the read-only identification word at offset 0x00.
REQ-003 Port clk SHALL be an input, 1 bit wide, and SHALL be the only clock, with all logic acting on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide, and SHALL be the asynchronous, active-high reset.
REQ-005 The write address channel SHALL be s_axi_awaddr (input, 32 bits), s_axi_awprot (input, 3 bits, ignored), s_axi_awvalid (input, 1 bit) and s_axi_awready (output, 1 bit).
REQ-006 The write data channel SHALL be s_axi_wdata (input, 32 bits), s_axi_wstrb (input, 4 bits), s_axi_wvalid (input, 1 bit) and s_axi_wready (output, 1 bit).
REQ-007 The write response channel SHALL be s_axi_bresp (output, 2 bits), s_axi_bvalid (output, 1 bit) and s_axi_bready (input, 1 bit).
REQ-008 The read address channel SHALL be s_axi_araddr (input, 32 bits), s_axi_arprot (input, 3 bits, ignored), s_axi_arvalid (input, 1 bit) and s_axi_arready (output, 1 bit).
REQ-009 The read data channel SHALL be s_axi_rdata (output, 32 bits), s_axi_rresp (output, 2 bits), s_axi_rvalid (output, 1 bit) and s_axi_rready (input, 1 bit).
REQ-010 Port ctrl_out SHALL be an output, 32 bits wide, and SHALL continuously drive the value of register 0x08.
REQ-011 Port status_in SHALL be an input, 32 bits wide, and SHALL be read at offset 0x0C.

Function
REQ-012 The register map SHALL be as follows, with word index = addr[5:2] and addr[1:0] ignored:
- 0x00: ID_VALUE, read-only.
- 0x04: write counter, read-only.
- 0x08: control register, read/write.
- 0x0C: status_in, read-only.
- 0x10 to 0x3C: scratch registers, read/write.
REQ-013 An address is valid only when addr[31:6]==0; an access to any other address SHALL be an out-of-range access.
REQ-014 The write address and write data channels SHALL be accepted independently.
REQ-015 s_axi_awready SHALL be high only when no address is held and s_axi_bvalid is low.
REQ-016 s_axi_wready SHALL be high only when no data word is held and s_axi_bvalid is low.
REQ-017 The block SHALL commit a write in the first cycle in which both an address and a data word are held and s_axi_bvalid is low, and SHALL clear both holds in that cycle.
REQ-018 s_axi_bvalid SHALL rise in the cycle after the commit, so that AW and W arriving in the same cycle give bvalid 1 cycle after that handshake.
REQ-019 The block SHALL update each byte lane i of a read/write register only when s_axi_wstrb[i]=1; a wstrb of 0 SHALL leave the register unchanged and SHALL still respond OKAY.
REQ-020 A write to an out-of-range address SHALL change no register and SHALL respond SLVERR (2'b10).
REQ-021 A write to a read-only offset (0x00, 0x04, 0x0C) SHALL change no register and SHALL respond SLVERR.
REQ-022 Every other write SHALL respond OKAY (2'b00).
REQ-023 s_axi_bvalid and s_axi_bresp SHALL remain stable until s_axi_bready is high, and bvalid SHALL clear on the cycle of that handshake.
REQ-024 The write counter SHALL increment by 1 on each OKAY commit and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-025 s_axi_arready SHALL be high whenever s_axi_rvalid is low.
REQ-026 On an AR handshake, the block SHALL register s_axi_rdata and s_axi_rresp and SHALL assert s_axi_rvalid in the next cycle (1-cycle read latency).
REQ-027 On an out-of-range read, the block SHALL return s_axi_rdata=0 with s_axi_rresp=SLVERR; all in-range reads SHALL return OKAY.
REQ-028 status_in SHALL be sampled at the AR handshake cycle.
REQ-029 s_axi_rdata, s_axi_rresp and s_axi_rvalid SHALL remain stable until s_axi_rready is high, and rvalid SHALL clear on the cycle of that handshake.
REQ-030 The read and write paths SHALL operate concurrently; when an AR handshake and a write commit occur in the same cycle to the same register, the read SHALL return the pre-write value.
REQ-031 The block SHALL accept no new AR until the current R handshake completes, and SHALL not accept a back-to-back AR in the R handshake cycle.

Reset
REQ-032 While rst is high, the block SHALL drive all ready and valid outputs to 0, s_axi_bresp and s_axi_rresp to 2'b00, s_axi_rdata to 0 and ctrl_out to 0.
REQ-033 While rst is high, the block SHALL clear the write counter, all read/write registers and both AW and W holds.
REQ-034 The block SHALL assert s_axi_awready, s_axi_wready and s_axi_arready in the first clk cycle after rst deasserts.
REQ-035 An assertion of rst in the middle of a transaction SHALL abort it: any pending B or R SHALL be dropped, and no partial write SHALL remain in any register.

Verification
REQ-036 The bench SHALL cover a write followed by a read: AW 0x08 and W 0xA5A5_1234 with wstrb=F in the same cycle -> bvalid 1 cycle later with OKAY, ctrl_out=0xA5A5_1234 and counter=1; then AR 0x08 -> rvalid 1 cycle later with rdata=0xA5A5_1234.
REQ-037 The bench SHALL cover a byte-strobe write: W precedes AW by 3 cycles with wdata 0xFFFF_FFFF and wstrb=4'b0100 to 0x10 -> bvalid 1 cycle after AW, then a read of 0x10 -> 0x00FF_0000.
REQ-038 The bench SHALL cover error responses: a write to 0x00 -> SLVERR with ID unchanged and counter unchanged; a read of 0x40 -> rdata=0 with SLVERR; a read of 0x00 -> ID_VALUE with OKAY.
REQ-039 The bench SHALL cover backpressure: bready held low 5 cycles -> bvalid and bresp stable, and awready and wready low, for all 5 cycles.
REQ-040 The bench SHALL cover rready held low: rdata stable and arready low for the whole hold.
REQ-041 The bench SHALL cover counter wrap: the counter is forced to 0xFFFF_FFFF and one OKAY write is made -> a read of 0x04 returns 0.
REQ-042 The bench SHALL cover reset mid-transaction: rst is asserted while bvalid=1 -> bvalid=0 immediately, and the readies are 1 the first cycle after release.
